// File: rtl/rocc_mem_arbiter_if.sv
// Bundle between the RoCC requesters, the arbiter and the shared L1 data-cache port.
// Requester i occupies slice i of each flat per-requester vector.
interface rocc_mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int TAG_W   = 10
);
  localparam int LT = TAG_W - ID_W;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*40-1:0]   req_addr;
  logic [NUM_REQ*LT-1:0]   req_tag;
  logic [NUM_REQ*5-1:0]    req_cmd;
  logic [NUM_REQ*3-1:0]    req_typ;
  logic [NUM_REQ*64-1:0]   req_data;

  logic                    io_mem_req_valid;
  logic                    io_mem_req_ready;
  logic [39:0]             io_mem_req_bits_addr;
  logic [TAG_W-1:0]        io_mem_req_bits_tag;
  logic [4:0]              io_mem_req_bits_cmd;
  logic [2:0]              io_mem_req_bits_typ;
  logic                    io_mem_req_bits_phys;
  logic [63:0]             io_mem_req_bits_data;
  logic                    io_mem_resp_valid;
  logic [TAG_W-1:0]        io_mem_resp_bits_tag;
  logic [63:0]             io_mem_resp_bits_data;
  logic                    io_mem_resp_bits_nack;

  logic [NUM_REQ-1:0]      resp_valid;
  logic [LT-1:0]           resp_tag;
  logic [63:0]             resp_data;
  logic                    resp_nack;
  logic [NUM_REQ-1:0]      busy;
  logic                    err;

  modport slave (
    input  req_valid, req_addr, req_tag, req_cmd, req_typ, req_data,
           io_mem_req_ready, io_mem_resp_valid, io_mem_resp_bits_tag,
           io_mem_resp_bits_data, io_mem_resp_bits_nack,
    output req_ready, io_mem_req_valid, io_mem_req_bits_addr, io_mem_req_bits_tag,
           io_mem_req_bits_cmd, io_mem_req_bits_typ, io_mem_req_bits_phys,
           io_mem_req_bits_data, resp_valid, resp_tag, resp_data, resp_nack, busy, err
  );

  modport master (
    output req_valid, req_addr, req_tag, req_cmd, req_typ, req_data,
           io_mem_req_ready, io_mem_resp_valid, io_mem_resp_bits_tag,
           io_mem_resp_bits_data, io_mem_resp_bits_nack,
    input  req_ready, io_mem_req_valid, io_mem_req_bits_addr, io_mem_req_bits_tag,
           io_mem_req_bits_cmd, io_mem_req_bits_typ, io_mem_req_bits_phys,
           io_mem_req_bits_data, resp_valid, resp_tag, resp_data, resp_nack, busy, err
  );
endinterface

// File: rtl/rocc_mem_arbiter.sv
// Round-robin sharing of one L1 data-cache port among NUM_REQ RoCC accelerators,
// with ID-prefixed tags for response routing and per-requester in-flight tracking.
module rocc_mem_arbiter_cnt #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_below,
  output logic o_busy,
  output logic o_uflow
);
  logic [CNT_W-1:0] r_cnt;

  assign o_below = r_cnt < CNT_W'(MAX_OUT);
  assign o_busy  = r_cnt != '0;
  // A response with nothing in flight is stale: the count holds at zero.
  assign o_uflow = i_dec && !i_inc && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset)                                r_cnt <= '0;
    else if (i_inc && !i_dec)                 r_cnt <= r_cnt + 1'b1;
    else if (i_dec && !i_inc && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end
endmodule

module rocc_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int TAG_W   = 10,
  parameter int MAX_OUT = 4
) (
  input logic              clk,
  input logic              reset,
  rocc_mem_arbiter_if.slave bus
);
  localparam int LT    = TAG_W - ID_W;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]         r_state;
  logic [ID_W-1:0]    r_rr_ptr, r_hold_id;
  logic               r_err;
  logic [NUM_REQ-1:0] w_below, w_elig, w_inc, w_dec, w_uflow, w_busy, w_rsp;
  logic [ID_W-1:0]    w_srch, w_gnt, w_rid;
  logic               w_mvalid, w_fire, w_drop, w_bad_rid;

  assign w_elig = bus.req_valid & w_below;

  // Walk from the highest offset down so the lowest offset after rr_ptr wins.
  always_comb begin
    w_srch = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_elig[(int'(r_rr_ptr) + k) % NUM_REQ])
        w_srch = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
  end

  assign w_gnt    = (r_state == S_HOLD) ? r_hold_id : w_srch;
  assign w_mvalid = !reset && ((r_state == S_HOLD) ? bus.req_valid[r_hold_id] : |w_elig);
  assign w_fire   = w_mvalid && bus.io_mem_req_ready;
  assign w_drop   = (r_state == S_HOLD) && !bus.req_valid[r_hold_id];

  assign w_rid     = bus.io_mem_resp_bits_tag[TAG_W-1 -: ID_W];
  assign w_bad_rid = bus.io_mem_resp_valid && (int'(w_rid) >= NUM_REQ);

  always_comb begin
    w_rsp = '0;
    w_inc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp[i] = !reset && bus.io_mem_resp_valid && (w_rid == ID_W'(i));
      w_inc[i] = w_fire && (w_gnt == ID_W'(i));
    end
  end
  assign w_dec = w_rsp;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      rocc_mem_arbiter_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_inc[g]),
        .i_dec   (w_dec[g]),
        .o_below (w_below[g]),
        .o_busy  (w_busy[g]),
        .o_uflow (w_uflow[g])
      );
    end
  endgenerate

  assign bus.req_ready             = w_inc;
  assign bus.io_mem_req_valid      = w_mvalid;
  assign bus.io_mem_req_bits_addr  = bus.req_addr[w_gnt*40 +: 40];
  assign bus.io_mem_req_bits_tag   = {w_gnt, bus.req_tag[w_gnt*LT +: LT]};
  assign bus.io_mem_req_bits_cmd   = bus.req_cmd[w_gnt*5 +: 5];
  assign bus.io_mem_req_bits_typ   = bus.req_typ[w_gnt*3 +: 3];
  assign bus.io_mem_req_bits_phys  = 1'b1;
  assign bus.io_mem_req_bits_data  = bus.req_data[w_gnt*64 +: 64];
  assign bus.resp_valid            = w_rsp;
  assign bus.resp_tag              = bus.io_mem_resp_bits_tag[LT-1:0];
  assign bus.resp_data             = bus.io_mem_resp_bits_data;
  assign bus.resp_nack             = bus.io_mem_resp_bits_nack;
  assign bus.busy                  = w_busy;
  assign bus.err                   = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_hold_id <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_fire) r_rr_ptr <= ID_W'((int'(w_gnt) + 1) % NUM_REQ);
      case (r_state)
        S_IDLE: if (|w_elig && !bus.io_mem_req_ready) begin
          r_state   <= S_HOLD;
          r_hold_id <= w_gnt;
        end
        default: if (w_fire || w_drop) r_state <= S_IDLE;
      endcase
      if (w_drop || w_bad_rid || |w_uflow) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rocc_mem_arbiter.sv
// Directed bench for rocc_mem_arbiter with NUM_REQ=2, ID_W=1, TAG_W=10, MAX_OUT=4.
module tb_rocc_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  rocc_mem_arbiter_if #(.NUM_REQ(2), .ID_W(1), .TAG_W(10)) bus ();

  rocc_mem_arbiter #(.NUM_REQ(2), .ID_W(1), .TAG_W(10), .MAX_OUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.req_valid = 2'b00;
    bus.io_mem_req_ready = 1'b0;
    bus.io_mem_resp_valid = 1'b0;
    bus.io_mem_resp_bits_tag = 10'h000;
    bus.io_mem_resp_bits_nack = 1'b0;
  endtask

  task automatic resp(input logic [9:0] tag);
    bus.io_mem_resp_valid = 1'b1;
    bus.io_mem_resp_bits_tag = tag;
    tick();
    bus.io_mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_chk++; if (bus.io_mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid got %b exp 0", bus.io_mem_req_valid); end
    n_chk++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b exp 00", bus.req_ready); end
    n_chk++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got %b exp 00", bus.resp_valid); end
    n_chk++; if (bus.busy !== 2'b00) begin n_fail++; $display("FAIL rst_busy got %b exp 00", bus.busy); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus.err); end
    n_chk++; if (bus.io_mem_req_bits_phys !== 1'b1) begin n_fail++; $display("FAIL phys got %b exp 1", bus.io_mem_req_bits_phys); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4];
    logic [9:0] exp_tag [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_tag = '{10'h011, 10'h222, 10'h011, 10'h222};
    bus.req_valid = 2'b11;
    bus.io_mem_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++; if (bus.req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", c, bus.req_ready, exp_rdy[c]); end
      n_chk++; if (bus.io_mem_req_bits_tag !== exp_tag[c]) begin n_fail++; $display("FAIL rr_tag[%0d] got %h exp %h", c, bus.io_mem_req_bits_tag, exp_tag[c]); end
      if (c == 1) begin
        n_chk++; if (bus.io_mem_req_bits_addr !== 40'h0000002000) begin n_fail++; $display("FAIL rr_addr got %h exp 2000", bus.io_mem_req_bits_addr); end
        n_chk++; if (bus.io_mem_req_bits_data !== 64'hBBBB) begin n_fail++; $display("FAIL rr_data got %h exp bbbb", bus.io_mem_req_bits_data); end
        n_chk++; if (bus.io_mem_req_bits_cmd !== 5'd1 || bus.io_mem_req_bits_typ !== 3'd3) begin n_fail++; $display("FAIL rr_cmdtyp got %0d/%0d exp 1/3", bus.io_mem_req_bits_cmd, bus.io_mem_req_bits_typ); end
      end
      tick();
    end
    quiet();
    #1;
    n_chk++; if (bus.busy !== 2'b11) begin n_fail++; $display("FAIL rr_busy got %b exp 11", bus.busy); end
    resp(10'h000); resp(10'h000); resp(10'h200); resp(10'h200);
    n_chk++; if (bus.busy !== 2'b00 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rr_drain busy/err got %b/%b exp 00/0", bus.busy, bus.err); end
  endtask

  task automatic test_hold();
    bus.req_valid = 2'b01;
    bus.io_mem_req_ready = 1'b0;
    #1;
    n_chk++; if (bus.io_mem_req_valid !== 1'b1 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL hold_c0 mvalid/ready got %b/%b exp 1/00", bus.io_mem_req_valid, bus.req_ready); end
    tick();
    bus.req_valid = 2'b11;
    for (int c = 1; c < 3; c++) begin
      #1;
      n_chk++; if (bus.io_mem_req_bits_tag !== 10'h011 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL hold_c%0d tag/ready got %h/%b exp 011/00", c, bus.io_mem_req_bits_tag, bus.req_ready); end
      tick();
    end
    bus.io_mem_req_ready = 1'b1;
    #1;
    n_chk++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL hold_accept got %b exp 01", bus.req_ready); end
    tick();
    n_chk++; if (bus.req_ready !== 2'b10 || bus.io_mem_req_bits_tag !== 10'h222) begin n_fail++; $display("FAIL hold_next ready/tag got %b/%h exp 10/222", bus.req_ready, bus.io_mem_req_bits_tag); end
    tick();
    quiet();
    resp(10'h000); resp(10'h200);
    n_chk++; if (bus.busy !== 2'b00 || bus.err !== 1'b0) begin n_fail++; $display("FAIL hold_drain busy/err got %b/%b exp 00/0", bus.busy, bus.err); end
  endtask

  task automatic test_max_out();
    bus.req_valid = 2'b01;
    bus.io_mem_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL max_issue[%0d] got %b exp 01", c, bus.req_ready); end
      tick();
    end
    n_chk++; if (bus.io_mem_req_valid !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL max_block mvalid/ready got %b/%b exp 0/00", bus.io_mem_req_valid, bus.req_ready); end
    n_chk++; if (bus.busy !== 2'b01) begin n_fail++; $display("FAIL max_busy got %b exp 01", bus.busy); end
    bus.io_mem_resp_valid = 1'b1;
    bus.io_mem_resp_bits_tag = 10'h003;
    #1;
    n_chk++; if (bus.resp_valid !== 2'b01 || bus.resp_tag !== 9'h003) begin n_fail++; $display("FAIL max_resp valid/tag got %b/%h exp 01/003", bus.resp_valid, bus.resp_tag); end
    n_chk++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL max_resp_ready got %b exp 00", bus.req_ready); end
    tick();
    bus.io_mem_resp_valid = 1'b0;
    #1;
    n_chk++; if (bus.io_mem_req_valid !== 1'b1 || bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL max_reelig mvalid/ready got %b/%b exp 1/01", bus.io_mem_req_valid, bus.req_ready); end
    tick();
    quiet();
    resp(10'h000); resp(10'h000); resp(10'h000);
    n_chk++; if (bus.busy !== 2'b01) begin n_fail++; $display("FAIL max_one_left got %b exp 01", bus.busy); end
    resp(10'h000);
    n_chk++; if (bus.busy !== 2'b00 || bus.err !== 1'b0) begin n_fail++; $display("FAIL max_drain busy/err got %b/%b exp 00/0", bus.busy, bus.err); end
  endtask

  task automatic test_same_cycle();
    bus.req_valid = 2'b10;
    bus.io_mem_req_ready = 1'b1;
    tick();
    bus.io_mem_resp_valid = 1'b1;
    bus.io_mem_resp_bits_tag = 10'h205;
    #1;
    n_chk++; if (bus.req_ready !== 2'b10 || bus.resp_valid !== 2'b10 || bus.resp_tag !== 9'h005) begin n_fail++; $display("FAIL same_cyc ready/rvalid/tag got %b/%b/%h exp 10/10/005", bus.req_ready, bus.resp_valid, bus.resp_tag); end
    tick();
    quiet();
    #1;
    n_chk++; if (bus.busy !== 2'b10 || bus.err !== 1'b0) begin n_fail++; $display("FAIL same_cyc_busy busy/err got %b/%b exp 10/0", bus.busy, bus.err); end
  endtask

  task automatic test_nack();
    bus.io_mem_resp_valid = 1'b1;
    bus.io_mem_resp_bits_tag = 10'h201;
    bus.io_mem_resp_bits_nack = 1'b1;
    bus.io_mem_resp_bits_data = 64'hDEAD_BEEF_0123_4567;
    #1;
    n_chk++; if (bus.resp_valid !== 2'b10 || bus.resp_nack !== 1'b1 || bus.resp_tag !== 9'h001) begin n_fail++; $display("FAIL nack_route valid/nack/tag got %b/%b/%h exp 10/1/001", bus.resp_valid, bus.resp_nack, bus.resp_tag); end
    n_chk++; if (bus.resp_data !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL nack_data got %h exp deadbeef01234567", bus.resp_data); end
    tick();
    quiet();
    #1;
    n_chk++; if (bus.busy !== 2'b00 || bus.err !== 1'b0) begin n_fail++; $display("FAIL nack_busy busy/err got %b/%b exp 00/0", bus.busy, bus.err); end
  endtask

  task automatic test_stale_resp();
    bus.io_mem_resp_valid = 1'b1;
    bus.io_mem_resp_bits_tag = 10'h004;
    #1;
    n_chk++; if (bus.resp_valid !== 2'b01 || bus.resp_tag !== 9'h004) begin n_fail++; $display("FAIL stale_route valid/tag got %b/%h exp 01/004", bus.resp_valid, bus.resp_tag); end
    tick();
    quiet();
    #1;
    n_chk++; if (bus.err !== 1'b1 || bus.busy !== 2'b00) begin n_fail++; $display("FAIL stale_err err/busy got %b/%b exp 1/00", bus.err, bus.busy); end
    tick(); tick(); tick();
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL stale_sticky got %b exp 1", bus.err); end
  endtask

  task automatic test_reset_mid_hold();
    bus.req_valid = 2'b01;
    bus.io_mem_req_ready = 1'b0;
    tick();
    reset = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    reset = 1'b0;
    #1;
    n_chk++; if (bus.io_mem_req_valid !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_hold mvalid/err got %b/%b exp 0/0", bus.io_mem_req_valid, bus.err); end
    bus.req_valid = 2'b10;
    bus.io_mem_req_ready = 1'b1;
    #1;
    n_chk++; if (bus.io_mem_req_valid !== 1'b1 || bus.req_ready !== 2'b10 || bus.io_mem_req_bits_tag !== 10'h222) begin n_fail++; $display("FAIL rst_idle mvalid/ready/tag got %b/%b/%h exp 1/10/222", bus.io_mem_req_valid, bus.req_ready, bus.io_mem_req_bits_tag); end
    tick();
    quiet();
    #1;
    n_chk++; if (bus.busy !== 2'b10 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_after busy/err got %b/%b exp 10/0", bus.busy, bus.err); end
  endtask

  initial begin
    bus.req_addr = {40'h0000002000, 40'h0000001000};
    bus.req_tag  = {9'h022, 9'h011};
    bus.req_cmd  = {5'd1, 5'd0};
    bus.req_typ  = {3'd3, 3'd2};
    bus.req_data = {64'hBBBB, 64'hAAAA};
    bus.io_mem_resp_bits_data = 64'h0;
    quiet();
    test_reset();
    test_round_robin();
    test_hold();
    test_max_out();
    test_same_cycle();
    test_nack();
    test_stale_resp();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rocc_mem_arbiter.md
Name: rocc_mem_arbiter

Overview:
- Shares one L1 data-cache request/response port (`io_mem_*`) between NUM_REQ RoCC accelerators (Accel0, Accel1, ...) attached behind a single RoCC slot.
- Round-robin arbitration on the request side. Holds the grant stable under backpressure.
- Prefixes each downstream tag with the requester ID and routes responses back by that ID.
- Tracks outstanding loads per requester, so each accelerator's busy bookkeeping stays correct.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ID_W, 1, requester-ID bits placed in tag MSBs; 2^ID_W >= NUM_REQ
TAG_W, 10, downstream tag width; requesters use the low TAG_W-ID_W bits
MAX_OUT, 4, max in-flight requests per requester (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accepted
req_addr  in  NUM_REQ*40  request address, requester i at [40i+39:40i]
req_tag  in  NUM_REQ*(TAG_W-ID_W)  requester-local tag
req_cmd  in  NUM_REQ*5  memory command
req_typ  in  NUM_REQ*3  access size
req_data  in  NUM_REQ*64  store data
io_mem_req_valid  out  1  downstream request valid
io_mem_req_ready  in  1  downstream ready
io_mem_req_bits_addr  out  40  muxed address
io_mem_req_bits_tag  out  TAG_W  {grant_id, req_tag[grant]}
io_mem_req_bits_cmd  out  5  muxed command
io_mem_req_bits_typ  out  3  muxed size
io_mem_req_bits_phys  out  1  constant 1
io_mem_req_bits_data  out  64  muxed store data
io_mem_resp_valid  in  1  response valid
io_mem_resp_bits_tag  in  TAG_W  response tag
io_mem_resp_bits_data  in  64  response data
io_mem_resp_bits_nack  in  1  request was nacked
resp_valid  out  NUM_REQ  routed response valid (one-hot or zero)
resp_tag  out  TAG_W-ID_W  response tag with ID stripped (shared by all)
resp_data  out  64  response data (shared)
resp_nack  out  1  nack flag (shared)
busy  out  NUM_REQ  outstanding[i] != 0
err  out  1  sticky protocol error

Behaviour:
- Reset clears the following:
  - rr_ptr=0, state=IDLE, all outstanding=0, err=0.
  - io_mem_req_valid=0, req_ready=0, resp_valid=0, busy=0.
- Eligibility: `elig[i] = req_valid[i] & (outstanding[i] < MAX_OUT)`.
- FSM IDLE:
  - grant = first eligible index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. This is combinational, so the same-cycle grant has zero-cycle latency.
  - io_mem_req_valid = |elig.
  - If `io_mem_req_ready`: handshake. `req_ready[grant]=1`, `rr_ptr <= (grant+1) mod NUM_REQ`, stay IDLE.
  - Else: latch `hold_id <= grant` and go to HOLD.
- FSM HOLD:
  - grant = hold_id; io_mem_req_valid = req_valid[hold_id]. The outstanding limit is not re-checked.
  - Handshake: `req_ready[hold_id]=1`, `rr_ptr <= hold_id+1`, go to IDLE.
  - If req_valid[hold_id] drops (protocol violation): set err, go to IDLE with no handshake.
- `req_ready[j]=0` for every j != grant in every state.
- Downstream bits: muxed from the granted requester; tag = {grant[ID_W-1:0], req_tag_grant}.
- Response routing (combinational, same cycle):
  - `rid = io_mem_resp_bits_tag[TAG_W-1:TAG_W-ID_W]`.
  - `resp_valid[rid] = io_mem_resp_valid` when rid < NUM_REQ.
  - resp_tag = low bits; resp_data and resp_nack pass through.
- Response with rid >= NUM_REQ: dropped (no resp_valid), err set.
- Outstanding[i] update each cycle:
  - +1 on an accepted handshake for i.
  - -1 on resp_valid[i] (nack responses included; a nack ends the transaction).
  - Both in the same cycle: unchanged.
  - Decrement at 0: stays 0, err set (stale or unexpected response).
- err is sticky; only reset clears it.
- Reset mid-transaction: all state cleared next edge. Late responses are still routed; counters saturate at 0 and err is set.
- Store and load commands are treated identically (each expects one response).

Test Plan:
- Both requesters valid continuously, ready=1, rr_ptr=0 -> grants 0,1,0,1 on consecutive cycles; downstream tags 0x000|t0, 0x200|t1.
- Req0 valid, ready=0 for 3 cycles, req1 asserts at cycle 1 -> grant stays 0 (HOLD); req0 handshakes on cycle 3 when ready=1; req1 is granted next cycle.
- Req0 issues 4 loads, no responses, MAX_OUT=4 -> 5th request is not eligible (io_mem_req_valid=0 if req1 idle), busy[0]=1; one response tag 0x003 -> resp_valid=01, resp_tag=3, outstanding 3, req0 eligible again.
- Same-cycle accept for req1 and response tag 0x205 -> outstanding[1] unchanged, resp_valid=10, resp_tag=5.
- Response tag 0x201 with nack=1 while outstanding[1]=1 -> resp_valid=10, resp_nack=1, busy[1] falls to 0.
- Response tag 0x004 with outstanding[0]=0, NUM_REQ=2 -> resp_valid=01, err=1 held until reset, counter stays 0. Assert reset mid-HOLD -> next cycle io_mem_req_valid=0, state IDLE, err=0.
